// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the time/date counter.
// Snapshots three fields per frame, converts them to BCD by repeated subtraction, and scans them out.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [5:0]  sec_bin,
  input  logic [5:0]  min_bin,
  input  logic [4:0]  hour_bin,
  input  logic [4:0]  day_bin,
  input  logic [3:0]  month_bin,
  input  logic [13:0] year_bin,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, YMOD, DIV, COMMIT} conv_state_t;

  conv_state_t state, state_n;

  logic [15:0] presc, presc_n;
  logic [2:0]  idx, idx_n;
  logic        presc_wrap, frame_end;
  logic        start;

  logic [3:0]  active [6];
  logic [3:0]  shadow [6];
  logic [3:0]  work   [6];

  logic [5:0]  w0, w1;
  logic [13:0] w2;
  logic        ysel;
  logic [1:0]  fidx;
  logic [3:0]  tens;
  logic [13:0] cur;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h00;
    endcase
  endfunction

  always_comb begin
    presc_wrap = (presc == 16'(SCAN_DIV - 1));
    presc_n    = presc_wrap ? '0 : presc + 16'd1;
    idx_n      = idx;
    if (presc_wrap) idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    frame_end  = presc_wrap && (idx == 3'd5);
  end

  always_comb begin
    case (fidx)
      2'd0:    cur = {8'd0, w0};
      2'd1:    cur = {8'd0, w1};
      default: cur = w2;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    state_n = ysel ? YMOD : DIV;
      YMOD:    if (w2 < 14'd100) state_n = DIV;
      DIV:     if (cur < 14'd10 && fidx == 2'd2) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      start <= 1'b1;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      ysel  <= 1'b0;
      fidx  <= '0;
      tens  <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
        work[i]   <= '0;
      end
    end else begin
      presc <= presc_n;
      idx   <= idx_n;
      start <= frame_end;
      if (frame_end) begin
        for (int unsigned i = 0; i < 6; i++) active[i] <= shadow[i];
      end
      case (state)
        IDLE: if (start) begin
          if (mode) begin
            w0   <= {1'b0, day_bin};
            w1   <= {2'b0, month_bin};
            w2   <= year_bin;
            ysel <= 1'b1;
          end else begin
            w0   <= {1'b0, hour_bin};
            w1   <= min_bin;
            w2   <= {8'd0, sec_bin};
            ysel <= 1'b0;
          end
        end
        LOAD: begin
          fidx <= '0;
          tens <= '0;
        end
        YMOD: if (w2 >= 14'd100) w2 <= w2 - 14'd100;
        // One field at a time: the remainder left in cur becomes the ones digit.
        DIV: begin
          if (cur >= 14'd10) begin
            case (fidx)
              2'd0:    w0 <= w0 - 6'd10;
              2'd1:    w1 <= w1 - 6'd10;
              default: w2 <= w2 - 14'd10;
            endcase
            tens <= tens + 4'd1;
          end else begin
            work[{fidx, 1'b0}] <= tens;
            work[{fidx, 1'b1}] <= cur[3:0];
            tens <= '0;
            fidx <= fidx + 2'd1;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < 6; i++) shadow[i] <= work[i];
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from next-cycle scan position so they line up with presc/idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= 7'b1000000;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (presc_n == '0) begin
        an  <= '1;
        seg <= '1;
        dp  <= 1'b1;
      end else begin
        an  <= ~(6'b000001 << idx_n);
        seg <= ~seg_pattern(active[idx_n]);
        dp  <= ~((idx_n == 3'd1) || (idx_n == 3'd3));
      end
    end
  end

endmodule
